uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_CNT, default 2604, clk cycles per bit (50 MHz clk, 19200 baud).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 RX  input  1  serial line; asynchronous to clk; idles high.
REQ-005 clr_rdy  input  1  one-cycle pulse; consumer acknowledges rx_data.
REQ-006 rx_data  output  8  last received byte, LSB first on the line.
REQ-007 rdy  output  1  high when rx_data holds a new byte; held until cleared.
REQ-008 frm_err  output  1  high when the stop bit of the last byte sampled low.

Function
REQ-009 RX SHALL pass through two flops before use; both flops are preset to 1; no other logic uses raw RX.
REQ-010 FSM SHALL have exactly two states: IDLE and RECEIVING.
REQ-011 IDLE -> RECEIVING SHALL occur when synchronized RX is 0.
- Same cycle: baud counter loaded with BAUD_CNT/2 (1302).
- Same cycle: bit counter cleared to 0.
REQ-012 In RECEIVING, baud counter (12 bits) SHALL decrement every clk; a shift event SHALL fire when it reaches 0.
REQ-013 On a shift event:
- synchronized RX enters shift register MSB (9-bit, right shift);
- baud counter reloads BAUD_CNT;
- bit counter (4 bits) increments.
REQ-014 Sample point SHALL be mid-bit: first sample about 1302 cycles after start detection, then every 2604 cycles.
REQ-015 If the first sample (start bit) is 1, the FSM SHALL abort to IDLE.
- No rdy.
- rx_data and frm_err unchanged.
REQ-016 After the 10th shift (start, 8 data, stop), the FSM SHALL return to IDLE.
- Next edge: rx_data = shift register [7:0].
- Next edge: frm_err = inverse of the stop sample.
- Next edge: rdy = 1.
REQ-017 rdy SHALL clear on the edge after clr_rdy is high, or on start-bit detection in IDLE; if set and clear coincide, set SHALL win.
REQ-018 rx_data and frm_err SHALL change only at frame completion (REQ-016).
REQ-019 A new start bit SHALL be accepted in the first IDLE cycle after a frame, whether or not rdy was cleared; an unread byte is overwritten.
REQ-020 Latency: rdy SHALL rise 9*BAUD_CNT + BAUD_CNT/2 + 4 cycles, +-2, after the RX falling edge at the pin.
REQ-021 While in IDLE, the baud counter SHALL hold; no decrementing outside RECEIVING.

Reset
REQ-022 On rst_n low, immediately and regardless of state:
- FSM = IDLE, rdy = 0, frm_err = 0, rx_data = 0x00;
- bit counter = 0, baud counter = BAUD_CNT;
- shift register = 0x1FF, sync flops = 1.
REQ-023 Reset mid-frame SHALL discard the partial byte; after release, the block SHALL wait for a fresh high-to-low transition.
- Low RX already present at release SHALL be treated as a start bit only after the sync delay.

Verification
REQ-024 Loopback from UART_tx, tx_data=0xA5 -> rdy rises about 24740 cycles after trmt; rx_data=0xA5, frm_err=0.
REQ-025 Back-to-back bytes 0x00 then 0xFF, no clr_rdy -> both received; rx_data=0x00 then 0xFF; rdy stays high across the second frame only from its completion.
REQ-026 RX low for 500 cycles, then high -> FSM returns to IDLE; rdy stays 0; rx_data unchanged.
REQ-027 Byte 0x3C with stop bit forced low -> rdy=1, rx_data=0x3C, frm_err=1; next good byte clears frm_err.
REQ-028 clr_rdy pulse while rdy=1 -> rdy=0 next cycle; clr_rdy on the completion cycle -> rdy=1.
REQ-029 rst_n asserted during data bit 4 -> outputs reset immediately; next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first: rdy rises 9*BAUD_CNT + BAUD_CNT/2 + 4 cycles after the RX falling edge.
// No backpressure: rdy is held until clr_rdy or the next start bit, and an unread byte is overwritten.
module uart_rx #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  typedef enum logic {IDLE, RECEIVING} state_e;

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_CNT);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_CNT / 2);

  state_e      state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic [11:0] baud_cnt_q;
  logic [11:0] baud_cnt_d;
  logic [3:0]  bit_cnt_q;
  logic [8:0]  shift_q;
  logic        done_q;
  logic        shift_evt;
  logic        start_det;

  // The sample fires on the cycle the counter would reach zero, giving exactly BAUD_CNT cycles per bit.
  always_comb begin
    baud_cnt_d = baud_cnt_q - 12'd1;
    shift_evt  = (state_q == RECEIVING) && (baud_cnt_d == 12'd0);
    start_det  = (state_q == IDLE) && !rx_sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= IDLE;
      baud_cnt_q <= BAUD_FULL;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 9'h1FF;
      done_q     <= 1'b0;
      rx_data    <= 8'h00;
      rdy        <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      done_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q    <= RECEIVING;
            baud_cnt_q <= BAUD_HALF;
            bit_cnt_q  <= 4'd0;
          end
        end
        RECEIVING: begin
          if (shift_evt) begin
            shift_q    <= {rx_sync_q, shift_q[8:1]};
            baud_cnt_q <= BAUD_FULL;
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            // A start bit that reads high at mid-bit was a glitch.
            if (bit_cnt_q == 4'd0 && rx_sync_q) begin
              state_q <= IDLE;
            end else if (bit_cnt_q == 4'd9) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (done_q) begin
        rdy     <= 1'b1;
        rx_data <= shift_q[7:0];
        frm_err <= ~shift_q[8];
      end else if (clr_rdy || start_det) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule
